// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3, one
//                iteration per clock) with valid/ready handshakes on the
//                input and output sides.
//                Optional macro BIN2BCD_BTB_EN enables back-to-back
//                acceptance directly from DONE into SHIFT.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int DATA_W = 6,
    parameter int NDIG   = 2,
    parameter int CNT_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   bin_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter value on the final iteration edge.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [4*NDIG-1:0]   w_bcd_adj;

    // One add-3 correction cell per BCD digit; illegal codes 10-15 map to 0.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        logic [3:0] w_dig;
        logic [3:0] w_adj;
        assign w_dig = bcd_q[4*g +: 4];
        // Correct a digit that would overflow past 9 after the next doubling.
        always_comb begin
            if (w_dig >= 4'd10) begin
                w_adj = 4'd0;
            end else if (w_dig >= 4'd5) begin
                w_adj = w_dig + 4'd3;
            end else begin
                w_adj = w_dig;
            end
        end
        assign w_bcd_adj[4*g +: 4] = w_adj;
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                busy    = 1'b1;
                // Corrected digits and the binary register shift as one word.
                bcd_d   = {w_bcd_adj[4*NDIG-2:0], shift_q[DATA_W-1]};
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
`ifdef BIN2BCD_BTB_EN
                // A retiring result frees the block for a new value this edge.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        shift_d = bin_in;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`else
                if (out_ready) begin
                    state_d = S_IDLE;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bcd_out = bcd_q;

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter for the 6-bit processor's display/output path.
- Runs the shift-and-add-3 (double-dabble) algorithm, one iteration per clock, with one add-3 correction cell applied per BCD digit.
- A valid/ready handshake on both sides lets the processor hand off a value and collect the packed BCD result without stalling its own datapath.

Parameters:
- DATA_W, 6, width of the binary input; also the number of iterations.
- NDIG, 2, number of BCD output digits; must satisfy 10^NDIG > 2^DATA_W - 1.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bin_in holds a value to convert.
- in_ready  output  1  block can accept a value this cycle.
- bin_in  input  DATA_W  unsigned binary value.
- out_valid  output  1  bcd_out holds a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- bcd_out  output  4*NDIG  packed BCD, digit 0 (ones) in bits [3:0].
- busy  output  1  high in the SHIFT state.

Behaviour:
- Reset: the rst_n low assertion acts immediately, with no clock edge.
  - State goes to IDLE; the counter, binary shift register and BCD register are cleared.
  - Outputs: in_ready=1, out_valid=0, busy=0, bcd_out=0.
  - Reset mid-conversion abandons the conversion; no partial result is ever flagged valid.
- States:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready at an edge: load shift_reg=bin_in, clear bcd_reg and counter, go to SHIFT.
  - SHIFT: busy=1, in_ready=0.
    - At each edge, every digit d of bcd_reg becomes d+3 if d>=5, else d. Codes 10-15 cannot occur with legal parameters; the cell maps them to 0.
    - Then {bcd_reg, shift_reg} shifts left by 1 and the counter increments.
    - At the edge where counter==DATA_W-1: go to DONE and set out_valid=1.
  - DONE: out_valid=1, bcd_out=bcd_reg held stable, in_ready=0 (see BTB_EN).
    - On out_valid&&out_ready at an edge: out_valid=0, go to IDLE.
- Latency:
  - Acceptance edge E0; out_valid is high after edge E(DATA_W), i.e. E6 at the default.
  - Minimum throughput without BTB_EN is one result per DATA_W+2 cycles.
- in_valid while busy or in DONE is ignored; the source must hold its value until in_ready.
- out_ready while out_valid=0 has no effect.
- bcd_out reflects the BCD register at all times. It is meaningful only when out_valid=1 and changes only in SHIFT.
- All arithmetic is unsigned per 4-bit digit. No carries between digits except through the shift.

Optional Feature:
- Macro: BIN2BCD_BTB_EN (back-to-back acceptance).
- Defined:
  - In DONE, in_ready = out_ready (combinational).
  - If out_ready&&in_valid at the same edge, the result is retired and the new bin_in is loaded directly into SHIFT, with no IDLE cycle. out_valid drops for that cycle.
  - Throughput becomes one result per DATA_W+1 cycles.
- Undefined: in DONE, in_ready=0; the block always returns through IDLE.

Test Plan:
- Reset then bin_in=0, in_valid=1 one cycle, out_ready=1 → out_valid after 6th edge, bcd_out=0x00, back to IDLE next edge.
- bin_in=63 → bcd_out=0x63. busy high exactly 6 cycles; in_ready low from acceptance until out handshake.
- bin_in=45, out_ready held 0 for 5 cycles after out_valid → bcd_out stays 0x45 and out_valid stays 1 throughout; retires on the first out_ready=1 edge.
- Sweep 0..63 with random out_ready stalls → every result equals the decimal of the input (e.g. 9→0x09, 10→0x10, 50→0x50). in_valid pulses during SHIFT are ignored.
- Assert rst_n=0 after the 3rd SHIFT edge of bin_in=37 → outputs reset immediately. After release, bin_in=12 converts to 0x12 with no trace of 37.
- With BIN2BCD_BTB_EN: values 17 then 58 offered back-to-back, out_ready=1 → 58 accepted on the same edge 0x17 retires, 0x58 valid 6 edges later. Without the macro, 58 is accepted one edge later.
